// File: rtl/clk_meas_pkg.sv
// Shared constants and state encoding for the clock frequency meter.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArm     = 2'd1,
        StMeasure = 2'd2,
        StDone    = 2'd3
    } meas_state_e;

    localparam int unsigned DEF_GATE_CYCLES = 50_000_000;
    localparam int unsigned DEF_CNT_WIDTH   = 32;
    localparam int unsigned SYNC_STAGES     = 2;

endpackage

// File: rtl/bit_sync.sv
// Generic multi-flop synchronizer for a single asynchronous bit.
module bit_sync
    import clk_meas_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of meas_clk over a fixed window of clk cycles and
// publishes the count (with a saturation flag) once per window.
module clk_freq_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 meas_clk,
    input  logic                 start,
    input  logic                 cont,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic                 overflow
);

    localparam int unsigned WIN_WIDTH = $clog2(GATE_CYCLES + 1);
    localparam logic [WIN_WIDTH-1:0] WIN_LAST = WIN_WIDTH'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    meas_state_e          state_q;
    logic [WIN_WIDTH-1:0] win_q;
    logic [CNT_WIDTH-1:0] work_q;
    logic [CNT_WIDTH-1:0] work_d;
    logic                 sat_q;
    logic                 sat_d;
    logic                 sync_q;
    logic                 hist_q;
    logic                 edge_pulse;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_meas_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (meas_clk),
        .q       (sync_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= sync_q;
        end
    end

    assign edge_pulse = sync_q & ~hist_q;

    // Counter sticks at its maximum; an edge arriving there raises the flag.
    always_comb begin
        work_d = work_q;
        sat_d  = sat_q;
        if (edge_pulse) begin
            if (work_q == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                work_d = work_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            win_q      <= '0;
            work_q     <= '0;
            sat_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            edge_count <= '0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StArm;
                        busy    <= 1'b1;
                    end
                end
                StArm: begin
                    win_q   <= '0;
                    work_q  <= '0;
                    sat_q   <= 1'b0;
                    state_q <= StMeasure;
                end
                StMeasure: begin
                    work_q <= work_d;
                    sat_q  <= sat_d;
                    win_q  <= win_q + WIN_WIDTH'(1);
                    // Results are loaded on entry so they are valid during DONE.
                    if (win_q == WIN_LAST) begin
                        state_q    <= StDone;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        edge_count <= work_d;
                        overflow   <= sat_d;
                    end
                end
                StDone: begin
                    if (cont || start) begin
                        state_q <= StArm;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
